// File: rtl/waveform_array_seq.sv
// waveform_array_seq: fills a register array with a counting pattern a fixed
// number of times, holding the array stable for HOLD_CYCLES after every fill.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     begin a run (only honoured when idle)
//   mode      pattern select, latched when start is accepted
//   busy      high while filling or holding
//   done      one-cycle pulse at the end of a run
//   iter      current iteration index
//   io_a_b    iter[0]
//   io_a_c    ~iter[0]
//   wr_valid  high on cycles that write one array entry
//   wr_idx    entry written at the coming edge
//   a         registered array contents
module waveform_array_seq #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned NUM_ITER    = 4,
   parameter int unsigned HOLD_CYCLES = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           mode,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(NUM_ITER+1)-1:0]  iter,
   output logic                           io_a_b,
   output logic                           io_a_c,
   output logic                           wr_valid,
   output logic [$clog2(DEPTH+1)-1:0]     wr_idx,
   output logic [WIDTH-1:0]               a [DEPTH-1:0]
);

   localparam int unsigned IW = $clog2(NUM_ITER + 1);
   localparam int unsigned XW = $clog2(DEPTH + 1);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   // Sum width is wider than WIDTH so the addition itself never overflows;
   // the wrap happens only in the final truncation.
   localparam int unsigned SW = WIDTH + IW + XW + 1;

   typedef enum logic [1:0] {StIdle, StFill, StHold, StDone} state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic [XW-1:0]    wr_idx_q, wr_idx_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] a_q [DEPTH-1:0];
   logic [WIDTH-1:0] a_d [DEPTH-1:0];

   logic             last_wr, last_hold, last_iter;
   logic [WIDTH-1:0] wr_data;

   assign last_wr   = (wr_idx_q == XW'(DEPTH - 1));
   assign last_hold = (hold_q == HW'(HOLD_CYCLES - 1));
   assign last_iter = (iter_q == IW'(NUM_ITER - 1));

   assign wr_data = WIDTH'(SW'(iter_q) + SW'(1) + (mode_q ? SW'(wr_idx_q) : SW'(0)));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StFill;
         StFill: if (last_wr) state_d = StHold;
         StHold: if (last_hold) state_d = last_iter ? StDone : StFill;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      iter_d   = iter_q;
      wr_idx_d = wr_idx_q;
      hold_d   = hold_q;
      mode_d   = mode_q;
      a_d      = a_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               iter_d   = '0;
               wr_idx_d = '0;
               hold_d   = '0;
               mode_d   = mode;
            end
         end
         StFill: begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (wr_idx_q == XW'(i)) a_d[i] = wr_data;
            end
            if (last_wr) begin
               wr_idx_d = '0;
               hold_d   = '0;
            end else begin
               wr_idx_d = wr_idx_q + XW'(1);
            end
         end
         StHold: begin
            if (last_hold) begin
               hold_d = '0;
               if (!last_iter) iter_d = iter_q + IW'(1);
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_q   <= '0;
         wr_idx_q <= '0;
         hold_q   <= '0;
         mode_q   <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) a_q[i] <= '0;
      end else begin
         iter_q   <= iter_d;
         wr_idx_q <= wr_idx_d;
         hold_q   <= hold_d;
         mode_q   <= mode_d;
         a_q      <= a_d;
      end
   end

   // Outputs
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      wr_valid = 1'b0;
      unique case (state_q)
         StFill: begin
            busy     = 1'b1;
            wr_valid = 1'b1;
         end
         StHold: busy = 1'b1;
         StDone: done = 1'b1;
         default: ;
      endcase
   end

   assign iter   = iter_q;
   assign io_a_b = iter_q[0];
   assign io_a_c = ~iter_q[0];
   assign wr_idx = wr_idx_q;
   assign a      = a_q;

endmodule

// File: tb/tb_waveform_array_seq.sv
// Directed bench: default-parameter instance for main function, reset and
// start-handling; a WIDTH=2 instance for wrap; a minimal-size instance.
module tb_waveform_array_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance 0: defaults
   logic        start0, mode0, busy0, done0, io_b0, io_c0, wrv0;
   logic [2:0]  iter0, wri0;
   logic [15:0] a0 [3:0];
   // Instance 1: WIDTH=2
   logic        start1, mode1, busy1, done1, io_b1, io_c1, wrv1;
   logic [2:0]  iter1, wri1;
   logic [1:0]  a1 [3:0];
   // Instance 2: DEPTH=1, HOLD_CYCLES=1, NUM_ITER=1
   logic        start2, mode2, busy2, done2, io_b2, io_c2, wrv2;
   logic [0:0]  iter2, wri2;
   logic [15:0] a2 [0:0];

   waveform_array_seq u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .mode(mode0), .busy(busy0), .done(done0),
      .iter(iter0), .io_a_b(io_b0), .io_a_c(io_c0), .wr_valid(wrv0), .wr_idx(wri0), .a(a0)
   );

   waveform_array_seq #(.WIDTH(2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
      .iter(iter1), .io_a_b(io_b1), .io_a_c(io_c1), .wr_valid(wrv1), .wr_idx(wri1), .a(a1)
   );

   waveform_array_seq #(.DEPTH(1), .HOLD_CYCLES(1), .NUM_ITER(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2), .busy(busy2), .done(done2),
      .iter(iter2), .io_a_b(io_b2), .io_a_c(io_c2), .wr_valid(wrv2), .wr_idx(wri2), .a(a2)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int         lat;
      int         n;
      int         pulses;
      logic [3:0] seq;

      rst = 1'b1;
      start0 = 0; mode0 = 0; start1 = 0; mode1 = 0; start2 = 0; mode2 = 0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_wrv", wrv0, 0);
      chk("rst_io_b", io_b0, 0);
      chk("rst_io_c", io_c0, 1);
      chk("rst_iter", iter0, 0);
      chk("rst_a", {a0[3], a0[2], a0[1], a0[0]}, 0);
      rst = 1'b0;

      // Run 1: mode 0, stray start in FILL, mode toggled mid-run
      start0 = 1; mode0 = 0;
      @(negedge clk);
      start0 = 0;
      chk("r1_busy_rise", busy0, 1);
      lat = 0; n = 0; seq = '0;
      while (!done0 && lat < 200) begin
         start0 = (lat == 2);
         if (lat == 5) mode0 = 1;
         if (wrv0 && wri0 == 0) begin
            if (n < 4) seq[n] = io_b0;
            n++;
         end
         @(negedge clk);
         lat++;
      end
      chk("r1_done_seen", done0, 1);
      chk("r1_latency", lat, 56);
      chk("r1_iters", n, 4);
      chk("r1_io_b_seq", seq, 4'b1010);
      chk("r1_a", {a0[3], a0[2], a0[1], a0[0]}, {16'd4, 16'd4, 16'd4, 16'd4});
      // start during the done cycle must not restart
      start0 = 1;
      @(negedge clk);
      start0 = 0;
      chk("r1_done_width", done0, 0);
      pulses = 0;
      repeat (3) begin
         if (busy0 || done0) pulses++;
         @(negedge clk);
      end
      chk("r1_no_restart", pulses, 0);
      chk("r1_a_retained", {a0[3], a0[2], a0[1], a0[0]}, {16'd4, 16'd4, 16'd4, 16'd4});

      // Run 2: mode 1, mode dropped mid-run has no effect
      mode0 = 1; start0 = 1;
      @(negedge clk);
      start0 = 0;
      chk("r2_busy_rise", busy0, 1);
      repeat (4) @(negedge clk);
      mode0 = 0;
      lat = 4;
      chk("r2_hold_no_wr", wrv0, 0);
      chk("r2_a_iter0", {a0[3], a0[2], a0[1], a0[0]}, {16'd4, 16'd3, 16'd2, 16'd1});
      while (!done0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("r2_latency", lat, 56);
      chk("r2_a_final", {a0[3], a0[2], a0[1], a0[0]}, {16'd7, 16'd6, 16'd5, 16'd4});

      // Run 3: start held high gives back-to-back runs, then abort mid-HOLD of iter 2
      @(negedge clk);
      start0 = 1; mode0 = 0;
      lat = 0;
      while (!done0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("r3_done_seen", done0, 1);
      @(negedge clk);
      chk("r3_idle_gap", busy0, 0);
      @(negedge clk);
      chk("r3_back_to_back", busy0, 1);
      start0 = 0;
      lat = 0;
      while (!(iter0 == 2 && !wrv0) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("r3_reach_hold2", busy0 && !wrv0 && iter0 == 2, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy0, 0);
      chk("abort_done", done0, 0);
      chk("abort_iter", iter0, 0);
      chk("abort_io_c", io_c0, 1);
      chk("abort_a", {a0[3], a0[2], a0[1], a0[0]}, 0);
      pulses = 0;
      repeat (70) begin
         if (done0 || busy0) pulses++;
         @(negedge clk);
      end
      chk("abort_quiet", pulses, 0);

      // WIDTH=2, mode 1: 4..7 wraps to 0..3
      mode1 = 1; start1 = 1;
      @(negedge clk);
      start1 = 0; mode1 = 0;
      lat = 0;
      while (!done1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("w2_latency", lat, 56);
      chk("w2_a", {a1[3], a1[2], a1[1], a1[0]}, {2'd3, 2'd2, 2'd1, 2'd0});

      // Minimal instance: one write, done two cycles after busy rises
      start2 = 1; mode2 = 0;
      @(negedge clk);
      start2 = 0;
      chk("min_fill", {busy2, wrv2, wri2}, 3'b110);
      @(negedge clk);
      chk("min_hold", {busy2, wrv2, done2}, 3'b100);
      chk("min_a_hold", a2[0], 1);
      @(negedge clk);
      chk("min_done", done2, 1);
      chk("min_a_done", a2[0], 1);
      @(negedge clk);
      chk("min_idle", {busy2, done2}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/waveform_array_seq.md
WAVEFORM_ARRAY_SEQ -- requirements
Module: waveform_array_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of each array entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of unpacked array entries (>=1).
REQ-003 SHALL have parameter NUM_ITER, default 4, number of fill iterations per run (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 10, cycles the array is held stable after each fill (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request to begin a run; sampled only in IDLE.
REQ-008 SHALL have port mode  input  1  fill pattern select, latched when start is accepted.
REQ-009 SHALL have port busy  output  1  high in FILL and HOLD.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 SHALL have port iter  output  $clog2(NUM_ITER+1)  current iteration index.
REQ-012 SHALL have port io_a_b  output  1  equals iter[0].
REQ-013 SHALL have port io_a_c  output  1  equals ~iter[0].
REQ-014 SHALL have port wr_valid  output  1  high in FILL, one array write per cycle.
REQ-015 SHALL have port wr_idx  output  $clog2(DEPTH+1)  entry written this cycle.
REQ-016 SHALL have port a  output  unpacked [DEPTH-1:0] of WIDTH  registered array contents.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, HOLD, DONE.
REQ-018 IDLE: start=1 at an edge SHALL set iter=0, wr_idx=0, latch mode, go to FILL.
REQ-019 FILL: each cycle SHALL write a[wr_idx] at the next edge and increment wr_idx; after writing DEPTH-1, SHALL go to HOLD with hold counter 0 and wr_idx 0.
REQ-020 Written value SHALL be (iter+1) mod 2^WIDTH when mode=0, (iter+1+wr_idx) mod 2^WIDTH when mode=1.
REQ-021 HOLD: SHALL remain exactly HOLD_CYCLES cycles with no writes; on last cycle, if iter==NUM_ITER-1 go to DONE, else increment iter and go to FILL.
REQ-022 DONE: done SHALL be 1 for exactly one cycle, then IDLE; a SHALL retain final values.
REQ-023 Run latency: done SHALL assert exactly NUM_ITER*(DEPTH+HOLD_CYCLES) cycles after the first cycle busy is high.
REQ-024 start while busy or DONE SHALL be ignored; mode changes during a run SHALL have no effect.
REQ-025 start=1 in the cycle done is high SHALL be ignored; start held high into IDLE SHALL begin a new run.
REQ-026 Arithmetic SHALL be computed at >=WIDTH+1 bits then truncated to WIDTH (wrap, no saturation).
REQ-027 io_a_b/io_a_c SHALL change only when iter changes.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, iter=0, wr_idx=0, latched mode=0, hold counter=0, all a entries 0.
REQ-029 Reset outputs: busy=0, done=0, wr_valid=0, io_a_b=0, io_a_c=1.
REQ-030 rst SHALL take priority over start and any in-progress run; no done pulse on abort.

Verification
REQ-031 Defaults, mode=0, start pulse -> a={4,4,4,4} at done; done exactly 56 cycles after busy rises; io_a_b sequence 0,1,0,1.
REQ-032 Defaults, mode=1 -> after iter 0 a={1,2,3,4}; at done a[0..3]={4,5,6,7}.
REQ-033 WIDTH=2, mode=1 -> final a[0..3]={0,1,2,3} (wrap of 4..7).
REQ-034 rst asserted mid-HOLD of iter 2 -> next cycle busy=0, all a=0, iter=0, no done pulse.
REQ-035 start pulsed during FILL and in done cycle -> no restart, single done; start held high -> back-to-back runs.
REQ-036 DEPTH=1, HOLD_CYCLES=1, NUM_ITER=1 -> one write, done 2 cycles after busy rises.
